// File: rtl/fc_pkg.sv
// fc_pkg: state encoding and default sizes shared by the fc_input_packer and the layer it feeds.
package fc_pkg;
  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
  localparam int DATA_WIDTH  = 8;
  localparam int INPUT_NODES = 128;
endpackage

// File: rtl/fc_run_timer.sv
// fc_run_timer: loadable down-counter whose terminal count marks the end of the RUN window.
module fc_run_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             tc
);
  logic [WIDTH-1:0] count;
  assign tc = count == '0;
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (load) count <= load_value;
    else if (en && !tc) count <= count - 1'b1;
  end
endmodule

// File: rtl/fc_input_packer.sv
// fc_input_packer: packs a handshaked element stream into the FC layer's input vector and times the layer run.
// Define FC_PACK_ZERO_PAD_EN to let in_last end a fill early with zero-padded low slots.
module fc_input_packer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH   = fc_pkg::DATA_WIDTH,
  parameter int INPUT_NODES  = fc_pkg::INPUT_NODES,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  output logic [DATA_WIDTH*INPUT_NODES-1:0] input_fc,
  output logic                              layer_start,
  output logic                              layer_busy,
  output logic                              layer_done,
  input  logic                              done_ack,
  output logic                              short_vec
);
  localparam int CW = $clog2(INPUT_NODES + 1);
  localparam int RW = $clog2(INPUT_NODES + DRAIN_CYCLES + 1);
`ifdef FC_PACK_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] slot;
  logic full, last_hit, short_q, tc;
  assign slot        = CW'(INPUT_NODES - 1) - cnt;
  assign full        = cnt == CW'(INPUT_NODES - 1);
  assign last_hit    = PAD_EN & in_last;
  assign in_ready    = state == IDLE;
  assign layer_start = state == START;
  assign layer_busy  = state == RUN;
  assign layer_done  = state == DONE;
  assign short_vec   = PAD_EN & short_q;
  // The layer consumes the top slot first, so the fill runs from slot INPUT_NODES-1 downward.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      input_fc <= '0;
      short_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          input_fc[slot*DATA_WIDTH +: DATA_WIDTH] <= in_data;
          cnt <= cnt + 1'b1;
          if (full || last_hit) begin
            state   <= START;
            short_q <= !full;
          end
        end
        START: state <= RUN;
        RUN: if (tc) state <= DONE;
        DONE: if (done_ack) begin
          state    <= IDLE;
          cnt      <= '0;
          input_fc <= '0;
          short_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Loaded during START so RUN lasts exactly INPUT_NODES+DRAIN_CYCLES cycles.
  fc_run_timer #(.WIDTH(RW)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(state == START),
    .load_value(RW'(INPUT_NODES + DRAIN_CYCLES - 1)),
    .en(state == RUN),
    .tc(tc)
  );
endmodule
